// File: rtl/nibbler_pkg.sv
// Shared types for the Nibbler control slice: opcodes, ALU selects, FSM states, decoded control word.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LIT  = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3,
    OP_NORI = 4'h4, OP_CMPI = 4'h5, OP_IN   = 4'h6, OP_OUT  = 4'h7,
    OP_JMP  = 4'h8, OP_JC   = 4'h9, OP_JNC  = 4'hA, OP_JZ   = 4'hB,
    OP_JNZ  = 4'hC, OP_RSVD_D = 4'hD, OP_RSVD_E = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  localparam logic [4:0] ALU_PASSA = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00110;
  localparam logic [4:0] ALU_PASSB = 5'b11010;
  localparam logic [4:0] ALU_ADD   = 5'b01001;
  localparam logic [4:0] ALU_NOR   = 5'b10001;

  typedef enum logic [2:0] {S_FETCH, S_LOAD, S_EXEC, S_JOP, S_HALT} state_e;

  typedef enum logic [2:0] {C_ALWAYS, C_C, C_NC, C_Z, C_NZ} cond_e;

  typedef struct packed {
    logic [4:0] alu_sel;
    logic       ncin;
    logic       b_sel;
    logic       acc_we;
    logic       out_we;
    logic       flags_we;
    logic       is_jump;
    logic       is_halt;
    cond_e      cond;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '{alu_sel: ALU_PASSA, ncin: 1'b1, b_sel: 1'b0,
                                       acc_we: 1'b0, out_we: 1'b0, flags_we: 1'b0,
                                       is_jump: 1'b0, is_halt: 1'b0, cond: C_ALWAYS};

  function automatic logic cond_met(cond_e c, logic fc, logic fz);
    case (c)
      C_C:     return fc;
      C_NC:    return !fc;
      C_Z:     return fz;
      C_NZ:    return !fz;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_ctrl_decode.sv
// Combinational opcode decoder producing the control word used during S_EXEC / S_JOP.
module nibbler_decode
  import nibbler_pkg::*;
(
  input  opcode_e    opcode,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (opcode)
      OP_LIT:  begin ctrl.alu_sel = ALU_PASSB; ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1; end
      OP_ADDI: begin ctrl.alu_sel = ALU_ADD;   ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1; end
      OP_SUBI: begin
        ctrl.alu_sel = ALU_SUB; ctrl.ncin = 1'b0; ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1;
      end
      OP_NORI: begin ctrl.alu_sel = ALU_NOR;   ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1; end
      OP_CMPI: begin ctrl.alu_sel = ALU_SUB;   ctrl.ncin = 1'b0;   ctrl.flags_we = 1'b1; end
      OP_IN:   begin
        ctrl.alu_sel = ALU_PASSB; ctrl.b_sel = 1'b1; ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1;
      end
      OP_OUT:  begin ctrl.alu_sel = ALU_PASSA; ctrl.out_we = 1'b1; end
      OP_JMP:  begin ctrl.is_jump = 1'b1; ctrl.cond = C_ALWAYS; end
      OP_JC:   begin ctrl.is_jump = 1'b1; ctrl.cond = C_C;  end
      OP_JNC:  begin ctrl.is_jump = 1'b1; ctrl.cond = C_NC; end
      OP_JZ:   begin ctrl.is_jump = 1'b1; ctrl.cond = C_Z;  end
      OP_JNZ:  begin ctrl.is_jump = 1'b1; ctrl.cond = C_NZ; end
      OP_HALT: ctrl.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/nibbler_ctrl.sv
// Nibbler fetch/decode/execute sequencer. Optional single-step gating of S_FETCH via the
// NIBBLER_STEP_EN macro (adds the step input).
module nibbler_ctrl
  import nibbler_pkg::*;
#(
  parameter int unsigned PC_W = 12
) (
  input  logic            clk,
  input  logic            reset,
`ifdef NIBBLER_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  output logic [4:0]      alu_sel,
  output logic            alu_ncin,
  input  logic            alu_cout,
  input  logic            alu_eq,
  output logic            b_sel,
  output logic [3:0]      imm,
  output logic            acc_we,
  output logic            out_we,
  output logic            flag_c,
  output logic            flag_z,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            flag_c_q, flag_c_d;
  logic            flag_z_q, flag_z_d;
  logic            fetch_go;
  ctrl_word_t      dec;
  ctrl_word_t      ctrl;

`ifdef NIBBLER_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  nibbler_decode u_decode (
    .opcode (opcode_e'(ir_q[7:4])),
    .ctrl   (dec)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    ctrl     = CTRL_IDLE;
    case (state_q)
      S_FETCH: if (fetch_go) begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        ir_d    = rom_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ctrl = dec;
        if (dec.flags_we) begin
          flag_c_d = alu_cout;
          flag_z_d = alu_eq;
        end
        // Jumps step past the operand byte here so its ROM read lands in S_JOP.
        if (dec.is_jump) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_JOP;
        end else if (dec.is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_JOP: begin
        if (cond_met(dec.cond, flag_c_q, flag_z_q)) pc_d = PC_W'({ir_q[3:0], rom_data});
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Strobes stay quiet in any cycle where reset is sampled.
    if (reset) ctrl = CTRL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign rom_addr = pc_q;
  assign imm      = ir_q[3:0];
  assign alu_sel  = ctrl.alu_sel;
  assign alu_ncin = ctrl.ncin;
  assign b_sel    = ctrl.b_sel;
  assign acc_we   = ctrl.acc_we;
  assign out_we   = ctrl.out_we;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_nibbler_ctrl.sv
// Bench for nibbler_ctrl: instruction-level model expands each instruction into expected cycles.
module tb_nibbler_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [4:0]  alu_sel;
  logic        alu_ncin, alu_cout, alu_eq, b_sel, acc_we, out_we, flag_c, flag_z, halted;
  logic [3:0]  imm;
`ifdef NIBBLER_STEP_EN
  logic        step = 1'b1;
`endif

  logic [7:0]  rom [4096];
  int          checks = 0, errors = 0, cyc = 0;
  bit          chk_en = 1'b1;

  always #5 clk = ~clk;

  nibbler_ctrl #(.PC_W(12)) dut (
    .clk(clk), .reset(reset),
`ifdef NIBBLER_STEP_EN
    .step(step),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .alu_sel(alu_sel), .alu_ncin(alu_ncin),
    .alu_cout(alu_cout), .alu_eq(alu_eq), .b_sel(b_sel), .imm(imm), .acc_we(acc_we),
    .out_we(out_we), .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, got, exp, cyc, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct {
    int addr; int sel; int ncin; int bsel; int accwe; int outwe; int imm; int halt; int fc; int fz;
  } rec_t;

  rec_t q[$];
  int   m_pc, m_ir, m_c, m_z, m_halt;

  function automatic rec_t idle_rec(input int addr, input int ir, input int h);
    rec_t r;
    r = '{addr: addr, sel: 0, ncin: 1, bsel: 0, accwe: 0, outwe: 0,
          imm: ir % 16, halt: h, fc: m_c, fz: m_z};
    return r;
  endfunction

  task automatic gen();
    int p, p1, p2, ir, op, taken, fl;
    rec_t e;
    if (m_halt != 0) begin
      q.push_back(idle_rec(m_pc, m_ir, 1));
      return;
    end
    p  = m_pc;
    p1 = (p + 1) % 4096;
    p2 = (p + 2) % 4096;
    ir = int'(rom[p]);
    op = ir / 16;
    q.push_back(idle_rec(p, m_ir, 0));
    q.push_back(idle_rec(p1, m_ir, 0));
    m_ir = ir;
    e  = idle_rec(p1, ir, 0);
    fl = 0;
    case (op)
      1: begin e.sel = 5'b11010; e.accwe = 1; fl = 1; end
      2: begin e.sel = 5'b01001; e.accwe = 1; fl = 1; end
      3: begin e.sel = 5'b00110; e.ncin = 0; e.accwe = 1; fl = 1; end
      4: begin e.sel = 5'b10001; e.accwe = 1; fl = 1; end
      5: begin e.sel = 5'b00110; e.ncin = 0; fl = 1; end
      6: begin e.sel = 5'b11010; e.bsel = 1; e.accwe = 1; fl = 1; end
      7: begin e.sel = 5'b00000; e.outwe = 1; end
      default: ;
    endcase
    q.push_back(e);
    if (op >= 8 && op <= 12) begin
      taken = (op == 8) || (op == 9 && m_c == 1) || (op == 10 && m_c == 0) ||
              (op == 11 && m_z == 1) || (op == 12 && m_z == 0);
      q.push_back(idle_rec(p2, ir, 0));
      m_pc = (taken != 0) ? ((ir % 16) * 256 + int'(rom[p1])) : p2;
    end else begin
      m_pc = p1;
      if (op == 15) m_halt = 1;
    end
    if (fl != 0) begin
      m_c = int'(alu_cout);
      m_z = int'(alu_eq);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (reset) begin
      cyc = 0;
      q.delete();
      m_pc = 0; m_ir = 0; m_c = 0; m_z = 0; m_halt = 0;
      chk("rst_acc_we", int'(acc_we), 0);
      chk("rst_out_we", int'(out_we), 0);
    end else begin
      cyc++;
      if (chk_en) begin
        if (q.size() == 0) gen();
        r = q.pop_front();
        chk("rom_addr", int'(rom_addr), r.addr);
        chk("alu_sel", int'(alu_sel), r.sel);
        chk("alu_ncin", int'(alu_ncin), r.ncin);
        chk("b_sel", int'(b_sel), r.bsel);
        chk("acc_we", int'(acc_we), r.accwe);
        chk("out_we", int'(out_we), r.outwe);
        chk("imm", int'(imm), r.imm);
        chk("halted", int'(halted), r.halt);
        chk("flag_c", int'(flag_c), r.fc);
        chk("flag_z", int'(flag_z), r.fz);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rst_on();
    @(posedge clk); #2 reset = 1'b1;
  endtask

  task automatic rst_off();
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
  endtask

  task automatic upto(input int n);
    while (cyc < n) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_cout = 1'b0; alu_eq = 1'b0;
    fill();

    // 1: LIT 7, ADDI 3, OUT, HALT
    rst_on(); fill();
    rom[0] = 8'h17; rom[1] = 8'h23; rom[2] = 8'h70;
    alu_cout = 1'b0; alu_eq = 1'b0;
    rst_off();
    upto(1);  chk("t1_addr0", int'(rom_addr), 0);
    upto(3);  chk("t1_lit_we", int'(acc_we), 1); chk("t1_lit_sel", int'(alu_sel), 5'b11010);
              chk("t1_lit_imm", int'(imm), 7);
    upto(4);  chk("t1_addr1", int'(rom_addr), 1);
    upto(7);  chk("t1_addr2", int'(rom_addr), 2); chk("t1_fc", int'(flag_c), 0);
              chk("t1_fz", int'(flag_z), 0);
    upto(9);  chk("t1_out_we", int'(out_we), 1);
    upto(10); chk("t1_addr3", int'(rom_addr), 3);
    upto(14);

    // 2: CMPI 5 then JC taken to 0x421
    rst_on(); fill();
    rom[0] = 8'h55; rom[1] = 8'h94; rom[2] = 8'h21;
    alu_cout = 1'b1; alu_eq = 1'b0;
    rst_off();
    upto(3); chk("t2_cmp_acc_we", int'(acc_we), 0); chk("t2_cmp_ncin", int'(alu_ncin), 0);
    upto(4); chk("t2_fc", int'(flag_c), 1);
    upto(8); chk("t2_jc_target", int'(rom_addr), 12'h421);
    upto(12);

    // 2b: same with JNC, not taken -> start+2
    rst_on();
    rom[1] = 8'hA4;
    rst_off();
    upto(8); chk("t2_jnc_skip", int'(rom_addr), 3);
    upto(12);

    // 3: jump to 0xFFE, not-taken JC there wraps to 0
    rst_on(); fill();
    rom[0] = 8'h8F; rom[1] = 8'hFE; rom[12'hFFE] = 8'h90; rom[12'hFFF] = 8'h00;
    alu_cout = 1'b0; alu_eq = 1'b0;
    rst_off();
    upto(5); chk("t3_at_ffe", int'(rom_addr), 12'hFFE);
    upto(9); chk("t3_wrap", int'(rom_addr), 0);
    upto(20);

    // 4: reset during EXEC of ADDI
    rst_on(); fill();
    rom[0] = 8'h23;
    alu_cout = 1'b1; alu_eq = 1'b1;
    rst_off();
    @(posedge clk);
    rst_on();
    @(negedge clk); #1 chk("t4_exec_abort_we", int'(acc_we), 0);
    rst_off();
    upto(1); chk("t4_pc0", int'(rom_addr), 0); chk("t4_fc", int'(flag_c), 0);
             chk("t4_fz", int'(flag_z), 0);
    upto(6);

    // 4b: reset during S_JOP of JMP 0xFFE
    rst_on(); fill();
    rom[0] = 8'h8F; rom[1] = 8'hFE;
    rst_off();
    repeat (2) @(posedge clk);
    rst_on(); rst_off();
    upto(1); chk("t4_jop_abort", int'(rom_addr), 0);
    upto(6);

    // 5: HALT then 20 idle cycles
    rst_on(); fill();
    rst_off();
    upto(24); chk("t5_halted", int'(halted), 1); chk("t5_addr", int'(rom_addr), 1);
    rst_on(); rst_off();
    upto(1);  chk("t5_unhalt", int'(halted), 0);
    upto(3);

`ifdef NIBBLER_STEP_EN
    // 6: step gating
    begin
      int n_we;
      chk_en = 1'b0;
      rst_on(); fill();
      rom[0] = 8'h23; rom[1] = 8'h23;
      step = 1'b0;
      rst_off();
      for (int i = 0; i < 10; i++) begin
        @(negedge clk); #1 chk("t6_hold_addr", int'(rom_addr), 0);
      end
      @(posedge clk); #2 step = 1'b1;
      @(posedge clk); #2 step = 1'b0;
      n_we = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk); #1 if (acc_we) n_we++;
      end
      chk("t6_one_instr", n_we, 1);
      chk("t6_addr", int'(rom_addr), 1);
      step = 1'b1;
      chk_en = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
